// File: rtl/outport_arb.sv
// outport_arb: round-robin switch arbiter for one output port of a 5-port
// NoC router. It locks the port to one input from head flit to tail flit.
// Ports:
//   clk, rst_                 clock, synchronous active-low reset
//   req_i, port_i             request and requested output port of input i
//   ivalid_i, tail_i          flit transfer and tail marker of input i
//   dn_rdy                    downstream buffer of this port has space
//   grt_i                     grant to input i
//   sel                       crossbar select (owning input)
//   busy                      port is locked to an owner
//   pkt_cnt                   packets completed through this port
module outport_arb #(
    parameter int PORTID = 0
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        req_0,
    input  logic        req_1,
    input  logic        req_2,
    input  logic        req_3,
    input  logic        req_4,
    input  logic [2:0]  port_0,
    input  logic [2:0]  port_1,
    input  logic [2:0]  port_2,
    input  logic [2:0]  port_3,
    input  logic [2:0]  port_4,
    input  logic        ivalid_0,
    input  logic        ivalid_1,
    input  logic        ivalid_2,
    input  logic        ivalid_3,
    input  logic        ivalid_4,
    input  logic        tail_0,
    input  logic        tail_1,
    input  logic        tail_2,
    input  logic        tail_3,
    input  logic        tail_4,
    input  logic        dn_rdy,
    output logic        grt_0,
    output logic        grt_1,
    output logic        grt_2,
    output logic        grt_3,
    output logic        grt_4,
    output logic [2:0]  sel,
    output logic        busy,
    output logic [15:0] pkt_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [2:0] W_PID = 3'(PORTID);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_ptr;
    logic [2:0]  w_ptr_nxt;
    logic [2:0]  r_owner;
    logic [2:0]  w_owner_nxt;
    logic [15:0] r_pkt_cnt;
    logic [15:0] w_cnt_nxt;

    logic [4:0]  w_req;
    logic [4:0]  w_elig;
    logic [4:0]  w_ivalid;
    logic [4:0]  w_tail;
    logic [4:0]  w_grt;
    logic        w_found;
    logic [2:0]  w_pick;
    logic        w_own_grt;
    logic        w_release;
    logic        w_abort;
    logic [2:0]  w_ptr_adv;

    assign w_req    = {req_4, req_3, req_2, req_1, req_0};
    assign w_ivalid = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
    assign w_tail   = {tail_4, tail_3, tail_2, tail_1, tail_0};

    assign w_elig[0] = req_0 && (port_0 == W_PID);
    assign w_elig[1] = req_1 && (port_1 == W_PID);
    assign w_elig[2] = req_2 && (port_2 == W_PID);
    assign w_elig[3] = req_3 && (port_3 == W_PID);
    assign w_elig[4] = req_4 && (port_4 == W_PID);

    // First eligible input searching ptr, ptr+1, ... modulo 5.
    always_comb begin
        logic [3:0] idx;
        w_found = 1'b0;
        w_pick  = 3'd0;
        for (int k = 0; k < 5; k++) begin
            idx = {1'b0, r_ptr} + 4'(k);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!w_found && w_elig[idx[2:0]]) begin
                w_found = 1'b1;
                w_pick  = idx[2:0];
            end
        end
    end

    assign w_own_grt = (r_state == LOCKED) && dn_rdy;
    assign w_release = w_own_grt && w_ivalid[r_owner] && w_tail[r_owner];
    // Owner withdrew or retargeted its request: drop the lock uncounted.
    assign w_abort   = !w_elig[r_owner];
    assign w_ptr_adv = (r_owner == 3'd4) ? 3'd0 : r_owner + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_pkt_cnt;
        unique case (r_state)
            IDLE: begin
                if (dn_rdy && w_found) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = w_ptr_adv;
                    w_cnt_nxt   = r_pkt_cnt + 16'd1;
                end else if (w_abort) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = w_ptr_adv;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state   <= IDLE;
            r_ptr     <= 3'd0;
            r_owner   <= 3'd0;
            r_pkt_cnt <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_pkt_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_grt = 5'd0;
        if (w_own_grt) w_grt[r_owner] = 1'b1;
    end

    assign grt_0   = w_grt[0];
    assign grt_1   = w_grt[1];
    assign grt_2   = w_grt[2];
    assign grt_3   = w_grt[3];
    assign grt_4   = w_grt[4];
    assign sel     = r_owner;
    assign busy    = (r_state == LOCKED);
    assign pkt_cnt = r_pkt_cnt;

endmodule
